// File: rtl/spi_planificador_transacciones_pkg.sv
// rtl/spi_planificador_transacciones_pkg.sv - shared types and control-word layout for the SPI transaction scheduler
// Contents: state_t (scheduler FSM states), control-register bit offsets,
//           build_ctrl_word(len, send) -> 32-bit control word for a len-byte transfer.
package spi_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LOAD,
        S_CFG,
        S_POLL_WAIT,
        S_POLL,
        S_READ,
        S_DONE
    } state_t;

    localparam int SEND_BIT     = 0;
    localparam int CS_CTRL_BIT  = 1;
    localparam int ALL_1S_BIT   = 2;
    localparam int ALL_0S_BIT   = 3;
    localparam int N_TX_END_LSB = 4;
    localparam int N_TX_END_W   = 8;
    localparam int N_RX_END_LSB = 16;
    localparam int N_RX_END_W   = 9;

    // Both end fields carry the index of the last byte, i.e. len-1.
    function automatic logic [31:0] build_ctrl_word(input logic [15:0] len, input logic send);
        logic [15:0] last;
        logic [31:0] w;
        last = len - 16'd1;
        w = '0;
        w[SEND_BIT]    = send;
        w[CS_CTRL_BIT] = 1'b1;
        w[ALL_1S_BIT]  = 1'b0;
        w[ALL_0S_BIT]  = 1'b0;
        w[N_TX_END_LSB +: N_TX_END_W] = last[N_TX_END_W-1:0];
        w[N_RX_END_LSB +: N_RX_END_W] = last[N_RX_END_W-1:0];
        return w;
    endfunction

endpackage

// File: rtl/spi_planificador_transacciones_if.sv
// rtl/spi_planificador_transacciones_if.sv - register port between the scheduler and the SPI peripheral
// Signals: wr (write strobe), reg_sel (1 = data bank, 0 = control reg), addr (bank address),
//          wdata (write data), rdata (read data, combinational on reg_sel/addr).
// Modports: master = scheduler side, slave = peripheral side.
interface spi_planificador_transacciones_if #(
    parameter int N = 7
);
    logic        wr;
    logic        reg_sel;
    logic [N:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output wr, reg_sel, addr, wdata, input rdata);
    modport slave  (input wr, reg_sel, addr, wdata, output rdata);
endinterface

// File: rtl/spi_planificador_transacciones_rr_arbitro.sv
// rtl/spi_planificador_transacciones_rr_arbitro.sv - combinational round-robin arbiter
// Ports: req (request vector), ptr (highest-priority index) -> gnt (one-hot, 0 if no request),
//        next_ptr (winner+1 mod NREQ, or ptr when nothing is granted).
module rr_arbitro #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   next_ptr
);

    // Two passes give the wrapping search: indices at/after ptr first, then from 0.
    always_comb begin
        logic found;
        found    = 1'b0;
        gnt      = '0;
        next_ptr = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found    = 1'b1;
                gnt[i]   = 1'b1;
                next_ptr = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                gnt[i]   = 1'b1;
                next_ptr = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

endmodule

// File: rtl/spi_planificador_transacciones.sv
// rtl/spi_planificador_transacciones.sv - round-robin scheduler sharing one SPI peripheral between NREQ requesters
// Ports: clk, rst (async, active-high); requester side req_i, len_i, tx_byte_i, gnt_o, tx_idx_o,
//        rx_vld_o, rx_byte_o, rx_idx_o, done_o, err_o; reg_bus (master modport) to the peripheral.
// Option: SPI_SCHED_TIMEOUT_EN adds a poll timeout that aborts the transfer and pulses err_o.
module spi_planificador_transacciones
    import spi_sched_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int N        = 7,
    parameter int POLL_GAP = 4,
    parameter int TIMEOUT  = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*(N+2)-1:0] len_i,
    input  logic [NREQ*8-1:0]     tx_byte_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [N:0]            tx_idx_o,
    output logic                  rx_vld_o,
    output logic [7:0]            rx_byte_o,
    output logic [N:0]            rx_idx_o,
    output logic [NREQ-1:0]       done_o,
    output logic [NREQ-1:0]       err_o,
    spi_planificador_transacciones_if.master reg_bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LW = N + 2;
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    state_t         state;
    logic [PW-1:0]  ptr;
    logic [LW-1:0]  len_q;
    logic [LW-1:0]  k;
    logic [GW-1:0]  gap_cnt;
    logic [31:0]    ctrl_q;
    logic           wr_q;
    logic           reg_sel_q;
    logic [N:0]     addr_q;

    logic [NREQ-1:0] arb_gnt;
    logic [PW-1:0]   arb_next;
    logic [LW-1:0]   len_sel;
    logic [LW-1:0]   len_eff;
    logic [7:0]      tx_sel;
    logic            k_last;
    logic            send_busy;
    logic            unused_rdata;

    rr_arbitro #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req      (req_i),
        .ptr      (ptr),
        .gnt      (arb_gnt),
        .next_ptr (arb_next)
    );

    always_comb begin
        len_sel = '0;
        tx_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) len_sel = len_i[i*LW +: LW];
            if (gnt_o[i])   tx_sel  = tx_byte_i[i*8 +: 8];
        end
    end

    assign len_eff   = (len_sel == '0) ? LW'(1) : len_sel;
    // k is one bit wider than the address so len = 2**(N+1) ends at len-1 without wrap.
    assign k_last    = (k == len_q - 1'b1);
    assign send_busy = reg_bus.rdata[SEND_BIT];

    assign reg_bus.wr      = wr_q;
    assign reg_bus.reg_sel = reg_sel_q;
    assign reg_bus.addr    = addr_q;
    // The TX byte is looked up combinationally from tx_idx_o, so the bank write data is muxed here.
    assign reg_bus.wdata   = wr_q ? (reg_sel_q ? {24'h0, tx_sel} : ctrl_q) : 32'h0;
    assign rx_byte_o       = rx_vld_o ? reg_bus.rdata[7:0] : 8'h00;
    assign unused_rdata    = ^reg_bus.rdata[31:8];

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   to_cnt;
    logic [NREQ-1:0] err_q;
    logic            to_hit;
    assign to_hit = (to_cnt == TW'(TIMEOUT - 1));
    assign err_o  = err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign err_o = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            len_q     <= '0;
            k         <= '0;
            gap_cnt   <= '0;
            ctrl_q    <= '0;
            wr_q      <= 1'b0;
            reg_sel_q <= 1'b0;
            addr_q    <= '0;
            gnt_o     <= '0;
            tx_idx_o  <= '0;
            rx_vld_o  <= 1'b0;
            rx_idx_o  <= '0;
            done_o    <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
            to_cnt    <= '0;
            err_q     <= '0;
`endif
        end else begin
            done_o <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
            err_q  <= '0;
`endif
            case (state)
                S_IDLE: begin
                    if (|req_i) state <= S_ARB;
                end
                S_ARB: begin
                    // Requests may have dropped since IDLE; fall back rather than grant nothing.
                    if (|arb_gnt) begin
                        gnt_o     <= arb_gnt;
                        ptr       <= arb_next;
                        len_q     <= len_eff;
                        k         <= '0;
                        wr_q      <= 1'b1;
                        reg_sel_q <= 1'b1;
                        addr_q    <= '0;
                        tx_idx_o  <= '0;
                        state     <= S_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (k_last) begin
                        reg_sel_q <= 1'b0;
                        addr_q    <= '0;
                        tx_idx_o  <= '0;
                        ctrl_q    <= build_ctrl_word(16'(len_q), 1'b1);
                        state     <= S_CFG;
                    end else begin
                        k        <= k + 1'b1;
                        addr_q   <= addr_q + 1'b1;
                        tx_idx_o <= addr_q + 1'b1;
                    end
                end
                S_CFG: begin
                    wr_q    <= 1'b0;
                    gap_cnt <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
                    to_cnt  <= '0;
`endif
                    state   <= S_POLL_WAIT;
                end
                S_POLL_WAIT: begin
`ifdef SPI_SCHED_TIMEOUT_EN
                    to_cnt <= to_cnt + 1'b1;
                    if (to_hit) begin
                        wr_q   <= 1'b1;
                        ctrl_q <= build_ctrl_word(16'(len_q), 1'b0);
                        err_q  <= gnt_o;
                        state  <= S_DONE;
                    end else
`endif
                    if (gap_cnt == GW'(POLL_GAP - 1)) begin
                        state <= S_POLL;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_POLL: begin
`ifdef SPI_SCHED_TIMEOUT_EN
                    to_cnt <= to_cnt + 1'b1;
`endif
                    if (!send_busy) begin
                        k         <= '0;
                        reg_sel_q <= 1'b1;
                        addr_q    <= '0;
                        rx_vld_o  <= 1'b1;
                        rx_idx_o  <= '0;
                        state     <= S_READ;
                    end
`ifdef SPI_SCHED_TIMEOUT_EN
                    else if (to_hit) begin
                        // Clear send so the peripheral stops, then finish without reading back.
                        wr_q   <= 1'b1;
                        ctrl_q <= build_ctrl_word(16'(len_q), 1'b0);
                        err_q  <= gnt_o;
                        state  <= S_DONE;
                    end
`endif
                    else begin
                        gap_cnt <= '0;
                        state   <= S_POLL_WAIT;
                    end
                end
                S_READ: begin
                    if (k_last) begin
                        rx_vld_o  <= 1'b0;
                        reg_sel_q <= 1'b0;
                        addr_q    <= '0;
                        rx_idx_o  <= '0;
                        done_o    <= gnt_o;
                        state     <= S_DONE;
                    end else begin
                        k        <= k + 1'b1;
                        addr_q   <= addr_q + 1'b1;
                        rx_idx_o <= addr_q + 1'b1;
                    end
                end
                S_DONE: begin
                    wr_q      <= 1'b0;
                    reg_sel_q <= 1'b0;
                    gnt_o     <= '0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_planificador_transacciones.sv
// tb/tb_spi_planificador_transacciones.sv - directed self-checking bench for spi_planificador_transacciones
module tb_spi_planificador_transacciones;

    localparam int NREQ     = 2;
    localparam int N        = 7;
    localparam int POLL_GAP = 4;
    localparam int TIMEOUT  = 64;
    localparam int BUSY_CYC = 25;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_i = 2'b00;
    logic [17:0] len_i = '0;
    logic [15:0] tx_byte_i;
    logic [1:0]  gnt_o;
    logic [7:0]  tx_idx_o;
    logic        rx_vld_o;
    logic [7:0]  rx_byte_o;
    logic [7:0]  rx_idx_o;
    logic [1:0]  done_o;
    logic [1:0]  err_o;

    always #5 clk = ~clk;

    spi_planificador_transacciones_if #(.N(N)) reg_bus ();

    spi_planificador_transacciones #(
        .NREQ(NREQ), .N(N), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .len_i     (len_i),
        .tx_byte_i (tx_byte_i),
        .gnt_o     (gnt_o),
        .tx_idx_o  (tx_idx_o),
        .rx_vld_o  (rx_vld_o),
        .rx_byte_o (rx_byte_o),
        .rx_idx_o  (rx_idx_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .reg_bus   (reg_bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Requester data tables and peripheral model (RX = inverted TX bank after send clears).
    logic [7:0]  txtab0 [256];
    logic [7:0]  txtab1 [256];
    logic [7:0]  bank   [256];
    logic [7:0]  rx_mem [256];
    logic [31:0] ctrl_reg = 32'h0;
    int          busy = 0;
    logic        stuck = 1'b0;

    assign tx_byte_i     = {txtab1[tx_idx_o], txtab0[tx_idx_o]};
    assign reg_bus.rdata = reg_bus.reg_sel ? {24'h0, rx_mem[reg_bus.addr]} : ctrl_reg;

    always @(posedge clk) begin
        if (reg_bus.wr) begin
            if (reg_bus.reg_sel) bank[reg_bus.addr] <= reg_bus.wdata[7:0];
            else begin
                ctrl_reg <= reg_bus.wdata;
                busy     <= reg_bus.wdata[0] ? BUSY_CYC : 0;
            end
        end else if (busy == 1 && !stuck) begin
            ctrl_reg[0] <= 1'b0;
            busy        <= 0;
            for (int i = 0; i < 256; i++) rx_mem[i] <= ~bank[i];
        end else if (busy > 1) begin
            busy <= busy - 1;
        end
    end

    function automatic logic [7:0] exp_tx(input int r, input int i);
        return (r == 0) ? txtab0[i] : txtab1[i];
    endfunction

    // Monitor: per-transaction statistics and per-beat checks.
    int         exp_owner = 0;
    int         cyc = 0, gnt_cyc = 0, lat = 0;
    int         load_cnt = 0, rx_cnt = 0, ctrl_cnt = 0, done_cnt = 0;
    logic [31:0] last_ctrl = '0;
    logic [1:0] txn_gnt = '0, prev_gnt = '0;
    logic [7:0] last_load_addr = '0, last_rx_idx = '0, mon_exp;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (reg_bus.wr && reg_bus.reg_sel) begin
                check("load_addr", reg_bus.addr, load_cnt);
                check("load_idx", tx_idx_o, load_cnt);
                mon_exp = exp_tx(exp_owner, load_cnt);
                check("load_data", reg_bus.wdata, {24'h0, mon_exp});
                last_load_addr = reg_bus.addr;
                load_cnt++;
            end
            if (reg_bus.wr && !reg_bus.reg_sel) begin
                ctrl_cnt++;
                last_ctrl = reg_bus.wdata;
            end
            if (rx_vld_o) begin
                check("rx_idx", rx_idx_o, rx_cnt);
                check("rx_addr", reg_bus.addr, rx_cnt);
                mon_exp = ~exp_tx(exp_owner, rx_cnt);
                check("rx_byte", rx_byte_o, mon_exp);
                last_rx_idx = rx_idx_o;
                rx_cnt++;
            end
            if (done_o != 2'b00) begin
                done_cnt++;
                lat = cyc - gnt_cyc;
            end
            if (gnt_o != 2'b00 && prev_gnt == 2'b00) begin
                txn_gnt = gnt_o;
                gnt_cyc = cyc;
            end
            prev_gnt = gnt_o;
        end else begin
            prev_gnt = 2'b00;
        end
    end

    task automatic clear_stats();
        load_cnt = 0; rx_cnt = 0; ctrl_cnt = 0; done_cnt = 0;
        last_ctrl = '0; txn_gnt = '0; lat = 0;
    endtask

    task automatic wait_end(input int budget, output logic [1:0] d, output logic [1:0] e);
        bit seen;
        seen = 1'b0;
        d = '0;
        e = '0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done_o != 2'b00 || err_o != 2'b00) begin
                seen = 1'b1;
                d = done_o;
                e = err_o;
            end
        end
        check("wait_end", seen, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {gnt_o, tx_idx_o, rx_vld_o, rx_byte_o, rx_idx_o, done_o, err_o}, 0);
        check(tag, {reg_bus.wr, reg_bus.reg_sel, reg_bus.addr, reg_bus.wdata}, 0);
    endtask

    logic [1:0] d, e;
    logic [1:0] rr_seq [3];
    int         rr_len [3];
    bit         seen;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_out");
        rst = 1'b0;
        @(negedge clk);

        // Single requester, len 3
        txtab0[0] = 8'hA1; txtab0[1] = 8'hB2; txtab0[2] = 8'hC3;
        len_i[8:0] = 9'd3;
        exp_owner = 0;
        clear_stats();
        req_i = 2'b01;
        wait_end(200, d, e);
        req_i = 2'b00;
        #1;
        check("t1_done", d, 2'b01);
        check("t1_err", e, 2'b00);
        check("t1_gnt", txn_gnt, 2'b01);
        check("t1_loads", load_cnt, 3);
        check("t1_ctrl_cnt", ctrl_cnt, 1);
        check("t1_ctrl", last_ctrl, 32'h0002_0023);
        check("t1_rx_cnt", rx_cnt, 3);
        check("t1_latency", lat, 37);
        @(negedge clk);
        check("t1_gnt_clr", gnt_o, 2'b00);

        // Reset during POLL, then restart with requester 1
        len_i[8:0] = 9'd2;
        txtab0[0] = 8'h11; txtab0[1] = 8'h22;
        clear_stats();
        req_i = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk); #1;
            if (ctrl_cnt == 1) seen = 1'b1;
        end
        check("t4_cfg_seen", seen, 1);
        repeat (POLL_GAP + 1) @(negedge clk);
        rst = 1'b1;
        req_i = 2'b00;
        @(posedge clk); #1;
        check_outputs_zero("t4_rst_out");
        @(negedge clk);
        rst = 1'b0;
        txtab1[0] = 8'h10; txtab1[1] = 8'h20; txtab1[2] = 8'h30; txtab1[3] = 8'h40;
        len_i[17:9] = 9'd4;
        exp_owner = 1;
        clear_stats();
        req_i = 2'b10;
        wait_end(200, d, e);
        req_i = 2'b00;
        #1;
        check("t4_done", d, 2'b10);
        check("t4_gnt", txn_gnt, 2'b10);
        check("t4_loads", load_cnt, 4);
        check("t4_rx_cnt", rx_cnt, 4);
        check("t4_ctrl", last_ctrl, 32'h0003_0033);
        @(negedge clk);

        // Round robin with both requests held, pointer at 0
        txtab0[0] = 8'h5A; txtab0[1] = 8'hA5;
        txtab1[0] = 8'h3C;
        len_i = {9'd1, 9'd2};
        rr_seq[0] = 2'b01; rr_seq[1] = 2'b10; rr_seq[2] = 2'b01;
        rr_len[0] = 2;     rr_len[1] = 1;     rr_len[2] = 2;
        req_i = 2'b11;
        for (int j = 0; j < 3; j++) begin
            exp_owner = (rr_seq[j] == 2'b01) ? 0 : 1;
            clear_stats();
            wait_end(200, d, e);
            if (j == 2) req_i = 2'b00;
            #1;
            check("rr_done", d, rr_seq[j]);
            check("rr_gnt", txn_gnt, rr_seq[j]);
            check("rr_rx_cnt", rx_cnt, rr_len[j]);
        end
        @(negedge clk);

        // Maximum length: 256 bytes, no address wrap
        for (int i = 0; i < 256; i++) txtab0[i] = 8'(i) ^ 8'h5A;
        len_i[8:0] = 9'h100;
        exp_owner = 0;
        clear_stats();
        req_i = 2'b01;
        wait_end(1000, d, e);
        req_i = 2'b00;
        #1;
        check("t3_done", d, 2'b01);
        check("t3_loads", load_cnt, 256);
        check("t3_rx_cnt", rx_cnt, 256);
        check("t3_last_load", last_load_addr, 8'd255);
        check("t3_last_rx", last_rx_idx, 8'd255);
        check("t3_ctrl", last_ctrl, 32'h00FF_0FF3);
        @(negedge clk);

        // Request dropped during LOAD
        for (int i = 0; i < 5; i++) txtab0[i] = 8'(8'hC0 + i);
        len_i[8:0] = 9'd5;
        exp_owner = 0;
        clear_stats();
        req_i = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            if (load_cnt >= 1) seen = 1'b1;
        end
        check("t6_load_seen", seen, 1);
        req_i = 2'b00;
        wait_end(200, d, e);
        #1;
        check("t6_done", d, 2'b01);
        check("t6_loads", load_cnt, 5);
        check("t6_rx_cnt", rx_cnt, 5);
        repeat (20) @(negedge clk);
        #1;
        check("t6_done_once", done_cnt, 1);
        check("t6_idle_gnt", gnt_o, 2'b00);

`ifdef SPI_SCHED_TIMEOUT_EN
        // Send never clears: abort after TIMEOUT poll cycles
        stuck = 1'b1;
        txtab0[0] = 8'h01; txtab0[1] = 8'h02;
        len_i[8:0] = 9'd2;
        exp_owner = 0;
        clear_stats();
        req_i = 2'b01;
        wait_end(300, d, e);
        req_i = 2'b00;
        #1;
        check("to_err", e, 2'b01);
        check("to_done", d, 2'b00);
        check("to_rx_cnt", rx_cnt, 0);
        check("to_ctrl_cnt", ctrl_cnt, 2);
        check("to_ctrl", last_ctrl, 32'h0001_0012);
        stuck = 1'b0;
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
